uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised single-clock UART transmitter. It is the successor to the two-clock `uart_send` in the FPGA-RS422 link. An internal baud divider replaces the separate baud clock. Data width, parity mode and stop-bit count are configurable, and a small write FIFO allows back-to-back frames with no idle gap. It sits between the parallel host write interface and the RS-422 line driver, and drives `txd` directly.

## Interface
- `CLK_DIV`, 16: `clk_sample` cycles per serial bit. Range 2..65535.
- `DATA_BITS`, 8: data bits per frame. Range 5..8.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame. Legal values 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries. Power of two, 2..64.
- `clk_sample`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  DATA_BITS  write data.
- `wrn`  in  1  active-low write strobe, sampled every cycle.
- `txd`  out  1  serial line output; idles high.
- `send_over`  out  1  one-cycle pulse per completed frame.
- `busy`  out  1  high while a frame is on the line.
- `full`  out  1  FIFO holds FIFO_DEPTH words.
- `empty`  out  1  FIFO holds no words.
- `overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- **Reset values** (while `rst` is high, independent of clock): `txd`=1, `send_over`=0, `busy`=0, `full`=0, `empty`=1, `overflow`=0. Reset also clears the FIFO pointers/count, the baud counter and the bit counter, and puts the FSM in IDLE.
- **Writes**
  - Accepted on any edge where `wrn`=0 and `full`=0.
  - If `wrn`=0 and `full`=1, the word is dropped and `overflow` pulses high for the following cycle.
  - `full` is the pre-edge value. A write while full is rejected even if a pop occurs on the same edge.
- **FIFO**: circular buffer with wrap-around on both pointers. A simultaneous write and pop leaves the count unchanged.
- **FSM states and transitions**
  - IDLE → START when `empty`=0. The word is popped and loaded into the shift register on that edge.
  - START → DATA.
  - DATA → PAR when `PARITY`≠0, otherwise DATA → STOP. DATA shifts the LSB first, DATA_BITS bits.
  - PAR → STOP.
  - STOP → START when the FIFO is non-empty (pop on the same edge). Otherwise STOP → IDLE.
- **Bit timing**: each state other than IDLE holds its bit for exactly CLK_DIV cycles. The baud counter runs 0..CLK_DIV-1, and the state advances when it reaches CLK_DIV-1. STOP lasts STOP_BITS×CLK_DIV cycles.
- **Line levels**: `txd` is registered. Start bit = 0, data bits = `din` bits, stop bits = 1, idle = 1.
- **Parity**: odd mode sends the XOR of the data bits, inverted. Even mode sends the XOR of the data bits. Parity is computed over DATA_BITS only.
- **`busy`**: high in START, DATA, PAR and STOP; low in IDLE.
- **`send_over`**: pulses on the edge that leaves STOP, whether the FSM goes to IDLE or START.

## Timing
- **Latency**: a write accepted at edge k into an empty FIFO with the FSM in IDLE gives `empty`=0 after edge k. At edge k+1 the word is popped and `txd` falls to the start bit.
- **Frame length**: CLK_DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- **Back-to-back frames**: the next start bit immediately follows the last stop-bit cycle, with zero idle cycles.
- **Reset mid-frame**: `txd` returns to 1 asynchronously and the frame is truncated. No `send_over` is produced, and the FIFO contents are lost.
- **`din`**: sampled only on the accepting edge; later changes do not affect queued words.

## Test plan
- **8N1, single word.** Setup: CLK_DIV=16; one write of 0x4A while idle. Required response:
  - `txd` sequence 0,0,1,0,1,0,0,1,0,1, each bit exactly 16 cycles.
  - `send_over` pulses once, 160 cycles after the start bit begins.
  - `busy` is low afterwards.
- **Parity.** Write 0x4A, which has three ones. Even parity gives parity bit 1; odd parity gives parity bit 0. With 1 stop bit the frame is 176 cycles.
- **7 data bits, 2 stop bits.** DATA_BITS=7, STOP_BITS=2, write 0x55. Required `txd`: 0,1,0,1,0,1,0,1 followed by 32 high cycles, then `send_over`.
- **Back-to-back and overflow.** FIFO_DEPTH=4; write 0x01..0x06 on six consecutive edges. Required response:
  - Word 0x01 is popped at edge 2.
  - `full` rises after edge 5.
  - The 0x06 write is dropped with one `overflow` pulse.
  - Five frames 0x01..0x05 go out with no idle gap, giving five `send_over` pulses.
- **Reset mid-frame.** Assert `rst` during data bit 3 of a frame with two words queued. Required response:
  - `txd`=1 immediately, `busy`=0, `empty`=1.
  - No `send_over` pulse.
  - After release, the line stays idle until a new write.
- **Clear reset state.** Simultaneous write and pop at count 2 leaves the count at 2. Exercise pointer wrap-around with 3×FIFO_DEPTH words and check that the data order is preserved.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock UART transmitter with a small write FIFO.
// Each frame is a start bit, DATA_BITS data bits (LSB first), an optional
// parity bit and STOP_BITS stop bits. Every bit lasts CLK_DIV clk_sample
// cycles. Queued words go out back to back with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_sample,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wrn,
  output logic                 txd,
  output logic                 send_over,
  output logic                 busy,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              BW         = $clog2(CLK_DIV);
  localparam logic [BW-1:0]   BAUD_LAST  = BW'(CLK_DIV - 1);
  localparam logic [2:0]      DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [AW:0]     COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic            ODD        = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;
  logic [BW-1:0]        baud_cnt;
  logic                 bit_end;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 parity_bit, parity_next;
  logic                 txd_next, send_over_next;

  // FIFO status comes straight from the registered count.
  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign push    = !wrn && !full;
  assign head    = mem[rd_ptr];
  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == BAUD_LAST);

  // FIFO storage: written on every accepted write.
  // NOTE: the storage array has no reset; the pointers and count alone decide which words are valid.
  always_ff @(posedge clk_sample) begin
    if (push) mem[wr_ptr] <= din;
  end

  // FIFO pointers, occupancy and the dropped-write pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      overflow <= !wrn && full;
    end
  end

  // Frame sequencer: next state, FIFO pop and the next registered line level.
  // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    shift_next     = shift;
    parity_next    = parity_bit;
    bit_cnt_next   = bit_cnt;
    send_over_next = 1'b0;
    txd_next       = 1'b1;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            state_next   = (PARITY != 0) ? PAR : STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            shift_next   = shift >> 1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_next   = STOP;
          bit_cnt_next = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            send_over_next = 1'b1;
            if (!empty) begin
              pop        = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A popped word is latched together with its parity on the same edge.
    if (pop) begin
      shift_next   = head;
      parity_next  = (^head) ^ ODD;
      bit_cnt_next = '0;
    end

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PAR:     txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
  end

  // Sequencer registers; txd is registered so the line never glitches.
  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      send_over  <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= (state == IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
      bit_cnt    <= bit_cnt_next;
      shift      <= shift_next;
      parity_bit <= parity_next;
      txd        <= txd_next;
      send_over  <= send_over_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitter configurations driven from one shared
// write port. Each has a frame-level reference model compared every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_uart_tx_fifo;

  localparam int CD = 16;
  localparam int FD = 4;
  // cfg0 8N1, cfg1 8E1, cfg2 8O1, cfg3 7N2
  localparam logic [3:0][7:0] DBS  = {8'd7, 8'd8, 8'd8, 8'd8};
  localparam logic [3:0][7:0] PARS = {8'd0, 8'd1, 8'd2, 8'd0};
  localparam logic [3:0][7:0] SBS  = {8'd2, 8'd1, 8'd1, 8'd1};
  localparam logic [5:0]      RST_OBS = 6'b100010;  // txd,so,busy,full,empty,ovf

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wrn = 1'b1;
  logic [7:0]      din = 8'h00;
  logic            running = 1'b0;
  logic [3:0][5:0] obs_a;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int         DB   = int'(DBS[g]);
    localparam int         PAR  = int'(PARS[g]);
    localparam int         SB   = int'(SBS[g]);
    localparam int         FL   = CD * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);
    localparam logic [7:0] MASK = 8'((1 << DB) - 1);

    logic txd, send_over, busy, full, empty, overflow;

    uart_tx_fifo #(
      .CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(FD)
    ) dut (
      .clk_sample(clk),
      .rst       (rst),
      .din       (din[DB-1:0]),
      .wrn       (wrn),
      .txd       (txd),
      .send_over (send_over),
      .busy      (busy),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
    );

    assign obs_a[g] = {txd, send_over, busy, full, empty, overflow};

    // Frame-level model: a word queue plus the elapsed time of the frame on the line.
    logic [7:0] q[$];
    logic       active  = 1'b0;
    int         t       = 0;
    logic [7:0] fw      = 8'h00;
    logic       exp_so  = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       pre_full;
    logic [5:0] exp_obs;

    // Line level of frame bit idx (0 = start bit) for word w.
    function automatic logic level(input logic [7:0] w, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DB) return w[idx-1];
      if (PAR != 0 && idx == DB + 1) return (PAR == 1) ? ~(^w) : ^w;
      return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        active  = 1'b0;
        t       = 0;
        exp_so  = 1'b0;
        exp_ovf = 1'b0;
      end else begin
        pre_full = (q.size() == FD);
        exp_ovf  = !wrn && pre_full;
        exp_so   = 1'b0;
        if (active) begin
          if (t == FL - 1) begin
            active = 1'b0;
            exp_so = 1'b1;
          end else begin
            t++;
          end
        end
        if (!active && q.size() != 0) begin
          fw     = q.pop_front();
          active = 1'b1;
          t      = 0;
        end
        if (!wrn && !pre_full) q.push_back(din & MASK);
      end
    end

    always @(negedge clk) begin
      if (running) begin
        exp_obs = {active ? level(fw, t / CD) : 1'b1, exp_so, active,
                   (q.size() == FD), (q.size() == 0), exp_ovf};
        check($sformatf("cfg%0d_cycle", g), {26'd0, obs_a[g]}, {26'd0, exp_obs});
      end
    end
  end

  // send_over pulse counters, one per configuration.
  int so_cnt [4];
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (obs_a[i][4]) so_cnt[i]++;
  end

  // Line receiver on cfg0 (8N1): samples mid-bit and queues decoded bytes.
  logic       rx_on   = 1'b0;
  int         rx_t    = 0;
  int         rx_k;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (rst) begin
      rx_on = 1'b0;
    end else begin
      if (!rx_on && !obs_a[0][5]) begin
        rx_on = 1'b1;
        rx_t  = 0;
      end else if (rx_on) begin
        rx_t++;
      end
      if (rx_on && (rx_t % CD) == CD / 2) begin
        rx_k = rx_t / CD;
        if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = obs_a[0][5];
        if (rx_k == 9) begin
          rx_q.push_back(rx_byte);
          rx_on = 1'b0;
        end
      end
    end
  end

  logic [3:0][5:0] cap [200];

  task automatic step(input logic wr, input logic [7:0] d);
    wrn = !wr;
    din = d;
    @(posedge clk);
    @(negedge clk);
    wrn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic capture();
    for (int c = 0; c < 200; c++) begin
      cap[c] = obs_a;
      step(1'b0, 8'h00);
    end
  endtask

  function automatic int first_so(input int i);
    for (int c = 0; c < 200; c++) if (cap[c][i][4]) return c;
    return -1;
  endfunction

  function automatic logic all_idle();
    for (int i = 0; i < 4; i++) if (obs_a[i][3:1] != 3'b001) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_all_idle(input string name);
    int n = 0;
    while (!all_idle() && n < 4000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check({name, "_drain"}, 32'(n < 4000), 32'd1);
    idle(2);
  endtask

  initial begin
    int         so0, ok, line_act, n;
    logic [9:0] seq8;
    logic [7:0] seq7;

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("reset_cfg%0d", i), {26'd0, obs_a[i]}, {26'd0, RST_OBS});
    rst     = 1'b0;
    running = 1'b1;
    idle(3);

    // 8N1 / parity: single write of 0x4A while idle
    step(1'b1, 8'h4A);
    check("lat_empty", obs_a[0][1], 0);
    check("lat_txd_idle", obs_a[0][5], 1);
    step(1'b0, 8'h00);
    capture();
    seq8 = 10'b1010010100;
    ok = 0;
    for (int c = 0; c < 160; c++) if (cap[c][0][5] == seq8[c / CD]) ok++;
    check("8n1_bit_cycles", ok, 160);
    check("8n1_so_at", first_so(0), 160);
    so0 = 0;
    for (int c = 0; c < 200; c++) if (cap[c][0][4]) so0++;
    check("8n1_so_count", so0, 1);
    check("8n1_busy_in_stop", cap[159][0][3], 1);
    check("8n1_busy_after", cap[161][0][3], 0);
    check("even_parity_bit", cap[152][1][5], 1);
    check("odd_parity_bit", cap[152][2][5], 0);
    check("even_frame_len", first_so(1), 176);
    check("odd_frame_len", first_so(2), 176);

    // 7 data bits, 2 stop bits: 0x55
    idle(5);
    step(1'b1, 8'h55);
    step(1'b0, 8'h00);
    capture();
    seq7 = 8'b10101010;
    ok = 0;
    for (int c = 0; c < 160; c++) if (cap[c][3][5] == ((c < 128) ? seq7[c / CD] : 1'b1)) ok++;
    check("7n2_bit_cycles", ok, 160);
    check("7n2_so_at", first_so(3), 160);

    // Back-to-back and overflow: 0x01..0x06 on consecutive edges
    idle(5);
    rx_q.delete();
    so0 = so_cnt[0];
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(i));
      if (i == 1) begin
        check("b2b_e1_empty", obs_a[0][1], 0);
        check("b2b_e1_busy", obs_a[0][3], 0);
      end
      if (i == 2) begin
        check("b2b_e2_txd", obs_a[0][5], 0);
        check("b2b_e2_busy", obs_a[0][3], 1);
      end
      if (i == 4) check("b2b_e4_full", obs_a[0][2], 0);
      if (i == 5) begin
        check("b2b_e5_full", obs_a[0][2], 1);
        check("b2b_e5_ovf", obs_a[0][0], 0);
      end
      if (i == 6) check("b2b_e6_ovf", obs_a[0][0], 1);
    end
    step(1'b0, 8'h00);
    check("b2b_ovf_one_cycle", obs_a[0][0], 0);
    wait_all_idle("b2b");
    check("b2b_so_count", so_cnt[0] - so0, 5);
    check("b2b_rx_count", rx_q.size(), 5);
    for (int j = 0; j < rx_q.size() && j < 5; j++) check($sformatf("b2b_rx%0d", j), rx_q[j], j + 1);

    // Simultaneous write and pop at count 2
    idle(3);
    rx_q.delete();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    idle(158);
    step(1'b1, 8'h44);
    check("cnt2_so_at_pop", obs_a[0][4], 1);
    step(1'b1, 8'h55);
    check("cnt2_full_at3", obs_a[0][2], 0);
    step(1'b1, 8'h66);
    check("cnt2_full_at4", obs_a[0][2], 1);
    check("cnt2_no_ovf", obs_a[0][0], 0);
    wait_all_idle("cnt2");
    check("cnt2_rx_count", rx_q.size(), 6);
    for (int j = 0; j < rx_q.size() && j < 6; j++) check($sformatf("cnt2_rx%0d", j), rx_q[j], 8'h11 * (j + 1));

    // Reset mid-frame during data bit 3 with two words queued
    idle(3);
    rx_q.delete();
    step(1'b1, 8'hF0);
    step(1'b1, 8'hC3);
    step(1'b1, 8'h3C);
    idle(68);
    check("rstmid_busy_before", obs_a[0][3], 1);
    check("rstmid_txd_before", obs_a[0][5], 0);
    so0 = so_cnt[0];
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("rstmid_cfg%0d", i), {26'd0, obs_a[i]}, {26'd0, RST_OBS});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    line_act = 0;
    for (int c = 0; c < 300; c++) begin
      step(1'b0, 8'h00);
      if (obs_a[0][5] !== 1'b1 || obs_a[0][3] !== 1'b0) line_act++;
    end
    check("rstmid_line_idle", line_act, 0);
    check("rstmid_no_so", so_cnt[0] - so0, 0);
    check("rstmid_no_rx", rx_q.size(), 0);

    // Pointer wrap-around: 3 x FIFO_DEPTH words, paced by cfg0 full
    idle(3);
    rx_q.delete();
    for (int i = 0; i < 3 * FD; i++) begin
      n = 0;
      while (obs_a[0][2] && n < 2000) begin
        step(1'b0, 8'h00);
        n++;
      end
      check($sformatf("wrap_wait%0d", i), 32'(n < 2000), 32'd1);
      step(1'b1, 8'(8'hA0 + i));
    end
    wait_all_idle("wrap");
    check("wrap_rx_count", rx_q.size(), 3 * FD);
    for (int j = 0; j < rx_q.size() && j < 3 * FD; j++) check($sformatf("wrap_rx%0d", j), rx_q[j], 8'(8'hA0 + j));

    running = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
